// File: rtl/led_frame_serializer.sv
// rtl/led_frame_serializer.sv - parallel-in serial-out LED frame transmitter with idle gap
module led_frame_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int GAP       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             abort_in,
  output logic             d_out,
  output logic             ce_out,
  output logic             busy_out,
  output logic             done_out
);

  // Counter widths are kept at least one bit so degenerate DIV/GAP values still elaborate.
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [DW-1:0]    div_q,   div_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic [GW-1:0]    gap_q,   gap_d;
  logic             done_q,  done_d;
  logic             div_wrap;
  logic             head_bit;

  // The divider wrap marks the last clock of every bit period (and of every gap period).
  assign div_wrap  = (div_q == DIV_LAST);
  assign head_bit  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

  assign ready_out = (state_q == S_IDLE);
  assign busy_out  = (state_q != S_IDLE);
  assign ce_out    = (state_q == S_SHIFT) && div_wrap;
  assign d_out     = (state_q == S_SHIFT) && head_bit;
  assign done_out  = done_q;

  // Next-state logic: accept, shift/gap sequencing, completion pulse and abort override.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          state_d = S_SHIFT;
          shift_d = data_in;
          div_d   = '0;
          bit_d   = '0;
          gap_d   = '0;
        end
      end

      S_SHIFT: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (GAP == 0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          gap_d = gap_q + 1'b1;
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An abort throws the frame away without a completion pulse; it is ignored while idle
    // so that a simultaneous valid_in still gets accepted.
    if (abort_in && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      shift_d = '0;
      div_d   = '0;
      bit_d   = '0;
      gap_d   = '0;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

endmodule
